// File: rtl/wb_initiator_seq.sv
// wb_initiator_seq: valid/ready command stream -> Wishbone classic single-cycle master, one op in flight.
// Latency: accept at edge N, cyc/stb from N+1, response the cycle after ack (2 cycles min, 1 op / 3 cycles).
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. WB_INIT_TIMEOUT_EN adds the ack timeout.
module wb_initiator_seq #(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   ack_hit;
    logic   timeout;

    assign accept  = cmd_valid & cmd_ready;
    assign ack_hit = (state == BUS) & wbm_ack_i;

`ifdef WB_INIT_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == BUS) && !wbm_ack_i && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the edge closing the TIMEOUT_CYC-th BUS cycle; an ack on that same edge wins.
    assign timeout = (state == BUS) && !wbm_ack_i && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rsp_err_q <= 1'b0;
        end else if (ack_hit) begin
            rsp_err_q <= 1'b0;
        end else if (timeout) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYC[0], CNT_W[0]};
    assign timeout    = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = BUS;
            BUS:     if (ack_hit || timeout) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Bus fields hold their last value while idle; cyc/stb qualify them.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat   <= '0;
        end else begin
            if (accept) begin
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
            end
            if (ack_hit) begin
                rsp_dat <= wbm_we_o ? 32'h0 : wbm_dat_i;
            end else if (timeout) begin
                rsp_dat <= 32'hDEAD_BEEF;
            end
        end
    end
endmodule
